// File: rtl/addsub_oot_pkg.sv
// Shared definitions for the inverse add/sub core.
// - state_t       : join/resync state encoding
// - DEFAULT_WIDTH : default bits per I or Q component
package addsub_oot_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DRAIN_SUM  = 2'd1,
        DRAIN_DIFF = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_inv_lane.sv
// One-component inverse butterfly: a = (s+d)>>>1, b = (s-d)>>>1.
// Purely combinational. All operands and results are two's complement.
// Ports:
//   s, d : WIDTH-bit sum / difference component
//   a, b : WIDTH-bit reconstructed components
module addsub_inv_lane #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    logic signed [WIDTH:0] s_ext;
    logic signed [WIDTH:0] d_ext;
    logic signed [WIDTH:0] add_full;
    logic signed [WIDTH:0] sub_full;

    assign s_ext    = {s[WIDTH-1], s};
    assign d_ext    = {d[WIDTH-1], d};
    assign add_full = s_ext + d_ext;
    assign sub_full = s_ext - d_ext;

    // Halving a (WIDTH+1)-bit value of two WIDTH-bit operands always fits in WIDTH bits.
    assign a = WIDTH'(add_full >>> 1);
    assign b = WIDTH'(sub_full >>> 1);

endmodule

// File: rtl/addsub_inv_oot.sv
// Inverse add/sub core: reconstructs a = (sum+diff)/2 and b = (sum-diff)/2 from two
// AXI-stream inputs of {I, Q} samples, and resynchronises the inputs when their
// packet boundaries disagree by discarding the tail of the longer packet.
// Ports:
//   ap_clk, ap_rst_n          : clock, asynchronous active-low reset
//   sum_T*, diff_T*           : input streams (TDATA = {I, Q})
//   a_T*, b_T*                : registered output streams
//   err_count                 : saturating count of TLAST mismatches
module addsub_inv_oot
    import addsub_oot_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ERR_W = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,

    input  logic [2*WIDTH-1:0] sum_TDATA,
    input  logic               sum_TVALID,
    output logic               sum_TREADY,
    input  logic               sum_TLAST,

    input  logic [2*WIDTH-1:0] diff_TDATA,
    input  logic               diff_TVALID,
    output logic               diff_TREADY,
    input  logic               diff_TLAST,

    output logic [2*WIDTH-1:0] a_TDATA,
    output logic               a_TVALID,
    input  logic               a_TREADY,
    output logic               a_TLAST,

    output logic [2*WIDTH-1:0] b_TDATA,
    output logic               b_TVALID,
    input  logic               b_TREADY,
    output logic               b_TLAST,

    output logic [ERR_W-1:0]   err_count
);

    state_t               state_q;
    logic [2*WIDTH-1:0]   a_data_q, b_data_q;
    logic                 a_valid_q, b_valid_q;
    logic                 a_last_q, b_last_q;
    logic [ERR_W-1:0]     err_count_q;

    logic [WIDTH-1:0]     a_i, a_q, b_i, b_q;
    logic                 can_load;
    logic                 join_ok;
    logic                 sum_ready, diff_ready;

    addsub_inv_lane #(.WIDTH(WIDTH)) u_lane_i (
        .s (sum_TDATA[2*WIDTH-1:WIDTH]),
        .d (diff_TDATA[2*WIDTH-1:WIDTH]),
        .a (a_i),
        .b (b_i)
    );

    addsub_inv_lane #(.WIDTH(WIDTH)) u_lane_q (
        .s (sum_TDATA[WIDTH-1:0]),
        .d (diff_TDATA[WIDTH-1:0]),
        .a (a_q),
        .b (b_q)
    );

    // Both slots must be empty or draining this cycle before a new join.
    assign can_load = (~a_valid_q | a_TREADY) & (~b_valid_q | b_TREADY);
    assign join_ok  = (state_q == RUN) & sum_TVALID & diff_TVALID & can_load;

    always_comb begin
        sum_ready  = 1'b0;
        diff_ready = 1'b0;
        case (state_q)
            RUN: begin
                sum_ready  = join_ok;
                diff_ready = join_ok;
            end
            DRAIN_SUM:  sum_ready  = 1'b1;
            DRAIN_DIFF: diff_ready = 1'b1;
            default: ;
        endcase
    end

    // Readies are held low while reset is asserted, independent of state.
    assign sum_TREADY  = sum_ready & ap_rst_n;
    assign diff_TREADY = diff_ready & ap_rst_n;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= RUN;
            a_data_q    <= '0;
            b_data_q    <= '0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            a_last_q    <= 1'b0;
            b_last_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (join_ok) begin
                a_data_q  <= {a_i, a_q};
                b_data_q  <= {b_i, b_q};
                a_last_q  <= sum_TLAST | diff_TLAST;
                b_last_q  <= sum_TLAST | diff_TLAST;
                a_valid_q <= 1'b1;
                b_valid_q <= 1'b1;
            end else begin
                if (a_TREADY) a_valid_q <= 1'b0;
                if (b_TREADY) b_valid_q <= 1'b0;
            end

            case (state_q)
                RUN: begin
                    if (join_ok && (sum_TLAST != diff_TLAST)) begin
                        // The stream that ended early waits while the other drains.
                        state_q <= sum_TLAST ? DRAIN_DIFF : DRAIN_SUM;
                        if (err_count_q != '1) err_count_q <= err_count_q + 1'b1;
                    end
                end
                DRAIN_SUM: begin
                    if (sum_TVALID && sum_TLAST) state_q <= RUN;
                end
                DRAIN_DIFF: begin
                    if (diff_TVALID && diff_TLAST) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign a_TDATA   = a_data_q;
    assign a_TVALID  = a_valid_q;
    assign a_TLAST   = a_last_q;
    assign b_TDATA   = b_data_q;
    assign b_TVALID  = b_valid_q;
    assign b_TLAST   = b_last_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_addsub_inv_oot.sv
// Self-checking bench for addsub_inv_oot: table of hand-computed single beats, then
// streamed packet scenarios (backpressure, both mismatch directions, reset mid-packet)
// checked against a scoreboard of expected output beats.
module tb_addsub_inv_oot;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] diff;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] sum_TDATA = '0, diff_TDATA = '0;
    logic        sum_TVALID = 1'b0, sum_TLAST = 1'b0, sum_TREADY;
    logic        diff_TVALID = 1'b0, diff_TLAST = 1'b0, diff_TREADY;
    logic [31:0] a_TDATA, b_TDATA;
    logic        a_TVALID, a_TLAST, b_TVALID, b_TLAST;
    logic        a_TREADY = 1'b1, b_TREADY = 1'b1;
    logic [15:0] err_count;

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;
    bit    abort   = 1'b0;
    int    acc_cnt = 0;
    beat_t sum_q[$], diff_q[$], exp_a[$], exp_b[$];
    vec_t  vecs[9];

    addsub_inv_oot dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .sum_TDATA   (sum_TDATA),
        .sum_TVALID  (sum_TVALID),
        .sum_TREADY  (sum_TREADY),
        .sum_TLAST   (sum_TLAST),
        .diff_TDATA  (diff_TDATA),
        .diff_TVALID (diff_TVALID),
        .diff_TREADY (diff_TREADY),
        .diff_TLAST  (diff_TLAST),
        .a_TDATA     (a_TDATA),
        .a_TVALID    (a_TVALID),
        .a_TREADY    (a_TREADY),
        .a_TLAST     (a_TLAST),
        .b_TDATA     (b_TDATA),
        .b_TVALID    (b_TVALID),
        .b_TREADY    (b_TREADY),
        .b_TLAST     (b_TLAST),
        .err_count   (err_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference halving: integer arithmetic, floor via arithmetic shift of a 32-bit int.
    function automatic logic [15:0] half(input logic [15:0] s, input logic [15:0] d,
                                         input bit sub);
        int si, di, r;
        si = int'($signed(s));
        di = int'($signed(d));
        r  = sub ? (si - di) : (si + di);
        r  = r >>> 1;
        return r[15:0];
    endfunction

    function automatic logic [31:0] ref_a(input logic [31:0] s, input logic [31:0] d);
        return {half(s[31:16], d[31:16], 1'b0), half(s[15:0], d[15:0], 1'b0)};
    endfunction

    function automatic logic [31:0] ref_b(input logic [31:0] s, input logic [31:0] d);
        return {half(s[31:16], d[31:16], 1'b1), half(s[15:0], d[15:0], 1'b1)};
    endfunction

    function automatic logic [31:0] mk_word(input int seed);
        int hi, lo;
        hi = seed * 1237 - 20000;
        lo = seed * -3001 + 777;
        return {hi[15:0], lo[15:0]};
    endfunction

    task automatic add_sum_pkt(input int p, input int n);
        for (int k = 0; k < n; k++) sum_q.push_back('{mk_word(p * 100 + k), k == n - 1});
    endtask

    task automatic add_diff_pkt(input int p, input int n);
        for (int k = 0; k < n; k++) diff_q.push_back('{mk_word(p * 100 + k + 50), k == n - 1});
    endtask

    // Joined beats are always the first n words of each packet, last on the n-th.
    task automatic push_exp(input int p, input int n);
        logic [31:0] s, d;
        for (int k = 0; k < n; k++) begin
            s = mk_word(p * 100 + k);
            d = mk_word(p * 100 + k + 50);
            exp_a.push_back('{ref_a(s, d), k == n - 1});
            exp_b.push_back('{ref_b(s, d), k == n - 1});
        end
    endtask

    task automatic drive_sum();
        int   guard = 0;
        logic acc;
        @(posedge ap_clk); #1;
        while (sum_q.size() > 0 && !abort) begin
            sum_TDATA  = sum_q[0].data;
            sum_TLAST  = sum_q[0].last;
            sum_TVALID = 1'b1;
            @(negedge ap_clk);
            acc = sum_TREADY;
            @(posedge ap_clk); #1;
            if (acc) begin
                void'(sum_q.pop_front());
                guard = 0;
            end else if (++guard > 200) begin
                note_fail("sum stream stuck (timeout)");
                sum_q.delete();
            end
        end
        sum_TVALID = 1'b0;
        sum_TLAST  = 1'b0;
    endtask

    task automatic drive_diff();
        int   guard = 0;
        logic acc;
        @(posedge ap_clk); #1;
        while (diff_q.size() > 0 && !abort) begin
            diff_TDATA  = diff_q[0].data;
            diff_TLAST  = diff_q[0].last;
            diff_TVALID = 1'b1;
            @(negedge ap_clk);
            acc = diff_TREADY;
            @(posedge ap_clk); #1;
            if (acc) begin
                void'(diff_q.pop_front());
                guard = 0;
            end else if (++guard > 200) begin
                note_fail("diff stream stuck (timeout)");
                diff_q.delete();
            end
        end
        diff_TVALID = 1'b0;
        diff_TLAST  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        repeat (3) @(negedge ap_clk);
        check({name, " a beats missing"}, exp_a.size(), 0);
        check({name, " b beats missing"}, exp_b.size(), 0);
    endtask

    // Output scoreboard plus handshake rules, sampled mid-cycle.
    initial begin
        beat_t       e;
        bit          a_stall = 1'b0;
        logic [31:0] a_hold = '0;
        logic        a_hold_last = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (mon_en && ap_rst_n) begin
                if (a_stall) begin
                    check("a valid held under stall", a_TVALID, 1);
                    check("a data held under stall", a_TDATA, a_hold);
                    check("a last held under stall", a_TLAST, a_hold_last);
                end
                a_stall     = a_TVALID && !a_TREADY;
                a_hold      = a_TDATA;
                a_hold_last = a_TLAST;
                if (a_TVALID && a_TREADY) begin
                    if (exp_a.size() == 0) note_fail("a unexpected beat");
                    else begin
                        e = exp_a.pop_front();
                        check("a data", a_TDATA, e.data);
                        check("a last", a_TLAST, e.last);
                    end
                end
                if (b_TVALID && b_TREADY) begin
                    if (exp_b.size() == 0) note_fail("b unexpected beat");
                    else begin
                        e = exp_b.pop_front();
                        check("b data", b_TDATA, e.data);
                        check("b last", b_TLAST, e.last);
                    end
                end
                if ((a_TVALID && !a_TREADY) || (b_TVALID && !b_TREADY))
                    check("no join while slot stalled", {sum_TREADY, diff_TREADY}, 0);
                if (sum_TVALID && sum_TREADY) acc_cnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        vecs[0] = '{32'h0006FFFE, 32'h00020004, 32'h00040001, 32'h0002FFFD};
        vecs[1] = '{32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h00000000};
        vecs[2] = '{32'h80008000, 32'h7FFF7FFF, 32'hFFFFFFFF, 32'h80008000};
        vecs[3] = '{32'hFFFB0005, 32'h00000000, 32'hFFFD0002, 32'hFFFD0002};
        vecs[4] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'h00010001, 32'h00010001, 32'h00010001, 32'h00000000};
        vecs[6] = '{32'h0003FFFF, 32'h00000000, 32'h0001FFFF, 32'h0001FFFF};
        vecs[7] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000};
        vecs[8] = '{32'h00008000, 32'h00007FFF, 32'h0000FFFF, 32'h00008000};

        // Reset state, with inputs offering data.
        sum_TVALID  = 1'b1;
        diff_TVALID = 1'b1;
        repeat (2) @(negedge ap_clk);
        check("reset sum_TREADY", sum_TREADY, 0);
        check("reset diff_TREADY", diff_TREADY, 0);
        check("reset a_TVALID", a_TVALID, 0);
        check("reset b_TVALID", b_TVALID, 0);
        check("reset a_TDATA", a_TDATA, 0);
        check("reset b_TDATA", b_TDATA, 0);
        check("reset a_TLAST", a_TLAST, 0);
        check("reset err_count", err_count, 0);
        sum_TVALID  = 1'b0;
        diff_TVALID = 1'b0;
        ap_rst_n    = 1'b1;

        // Single-beat arithmetic table, one-cycle latency.
        for (int i = 0; i < 9; i++) begin
            @(posedge ap_clk); #1;
            sum_TDATA   = vecs[i].sum;
            diff_TDATA  = vecs[i].diff;
            sum_TVALID  = 1'b1;
            diff_TVALID = 1'b1;
            @(negedge ap_clk);
            check($sformatf("vec%0d join ready", i), {sum_TREADY, diff_TREADY}, 2'b11);
            @(posedge ap_clk); #1;
            sum_TVALID  = 1'b0;
            diff_TVALID = 1'b0;
            @(negedge ap_clk);
            check($sformatf("vec%0d a valid", i), {a_TVALID, b_TVALID}, 2'b11);
            check($sformatf("vec%0d a data", i), a_TDATA, vecs[i].a);
            check($sformatf("vec%0d b data", i), b_TDATA, vecs[i].b);
            check($sformatf("vec%0d last", i), {a_TLAST, b_TLAST}, 2'b00);
        end
        repeat (2) @(negedge ap_clk);
        check("idle a_TVALID after table", a_TVALID, 0);
        mon_en = 1'b1;

        // Two 8-word packets, a_TREADY toggling, b_TREADY high.
        add_sum_pkt(5, 8);  add_diff_pkt(5, 8);  push_exp(5, 8);
        add_sum_pkt(6, 8);  add_diff_pkt(6, 8);  push_exp(6, 8);
        done = 1'b0;
        fork
            begin
                fork
                    drive_sum();
                    drive_diff();
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge ap_clk); #1;
                    a_TREADY = ~a_TREADY;
                end
            end
        join
        wait_drain("backpressure");
        @(posedge ap_clk); #1;
        a_TREADY = 1'b1;
        wait_drain("backpressure tail");
        check("err after backpressure", err_count, 0);

        // Sum ends early: 4 vs 6, then aligned 4/4.
        add_sum_pkt(1, 4);  add_diff_pkt(1, 6);  push_exp(1, 4);
        add_sum_pkt(2, 4);  add_diff_pkt(2, 4);  push_exp(2, 4);
        fork drive_sum(); drive_diff(); join
        wait_drain("sum early");
        check("err after sum early", err_count, 1);

        // Diff ends early: 6 vs 3, then aligned 4/4.
        add_sum_pkt(3, 6);  add_diff_pkt(3, 3);  push_exp(3, 3);
        add_sum_pkt(4, 4);  add_diff_pkt(4, 4);  push_exp(4, 4);
        fork drive_sum(); drive_diff(); join
        wait_drain("diff early");
        check("err after diff early", err_count, 2);

        // Reset for one cycle while word 3 of 8 is on the inputs.
        acc_cnt = 0;
        add_sum_pkt(7, 8);  add_diff_pkt(7, 8);  push_exp(7, 8);
        fork
            drive_sum();
            drive_diff();
            begin
                int n = 0;
                while (acc_cnt < 2 && n < 100) begin
                    @(posedge ap_clk); #1;
                    n++;
                end
                if (acc_cnt < 2) note_fail("reset test: words 1-2 never accepted");
                @(negedge ap_clk); #2;
                ap_rst_n = 1'b0;
                abort    = 1'b1;
                #1;
                check("async reset a_TVALID", a_TVALID, 0);
                check("async reset b_TVALID", b_TVALID, 0);
                check("async reset err_count", err_count, 0);
                check("async reset sum_TREADY", sum_TREADY, 0);
                @(negedge ap_clk); #2;
                ap_rst_n = 1'b1;
            end
        join
        sum_q.delete();
        diff_q.delete();
        exp_a.delete();
        exp_b.delete();
        abort = 1'b0;
        @(negedge ap_clk);
        check("post reset a_TVALID", a_TVALID, 0);
        check("post reset err_count", err_count, 0);

        add_sum_pkt(8, 8);  add_diff_pkt(8, 8);  push_exp(8, 8);
        fork drive_sum(); drive_diff(); join
        wait_drain("after reset");
        check("err after fresh packet", err_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_inv_oot.md
# addsub_inv_oot

Inverse of the add/sub compute core. It takes the sum and difference streams (a+b, a−b) of complex sc16 samples and reconstructs a = (sum+diff)/2 and b = (sum−diff)/2 per I/Q component. It sits between two chdr_deframers and two chdr_framers inside an RFNoC block, in the position the forward core occupies. It has the same AXI-stream port style as the forward core, and it also resynchronises the two inputs when their packet boundaries disagree.

## Interface
Parameters:
- WIDTH, 16: bits per I or Q component; the data word is 2*WIDTH bits, {I, Q}, two's complement.
- ERR_W, 16: width of the mismatch counter.

Ports:
- ap_clk  in  1  the only clock.
- ap_rst_n  in  1  reset. Asynchronous, active-low.
- sum_TDATA/sum_TVALID/sum_TREADY/sum_TLAST  in/in/out/in  2*WIDTH/1/1/1  sum input stream.
- diff_TDATA/diff_TVALID/diff_TREADY/diff_TLAST  in/in/out/in  2*WIDTH/1/1/1  difference input stream.
- a_TDATA/a_TVALID/a_TREADY/a_TLAST  out/out/in/out  2*WIDTH/1/1/1  reconstructed a.
- b_TDATA/b_TVALID/b_TREADY/b_TLAST  out/out/in/out  2*WIDTH/1/1/1  reconstructed b.
- err_count  out  ERR_W  saturating count of tlast mismatches.

## Operation
- **Arithmetic**, per component:
  - Sign-extend each operand to WIDTH+1 bits.
  - s+d and s−d are computed in WIDTH+1 bits, then arithmetic shift right by 1 (floor), keeping the low WIDTH bits.
  - The result always fits, so no saturation is needed.
  - I and Q are independent; no carry crosses between them.
- **Output slots.** Each output has one register slot holding data, last and valid.
  - can_load = (~a_TVALID | a_TREADY) & (~b_TVALID | b_TREADY).
- **State machine**: RUN, DRAIN_SUM, DRAIN_DIFF.
- **RUN**:
  - sum_TREADY = diff_TREADY = sum_TVALID & diff_TVALID & can_load.
  - On a join beat, both slots load and set valid; a_TLAST = b_TLAST = sum_TLAST | diff_TLAST.
  - If sum_TLAST & ~diff_TLAST: increment err_count, go to DRAIN_DIFF.
  - If diff_TLAST & ~sum_TLAST: increment err_count, go to DRAIN_SUM.
  - Otherwise stay in RUN.
- **DRAIN_DIFF**:
  - diff_TREADY = 1 and sum_TREADY = 0; the discarded words produce no output.
  - When a diff beat with diff_TLAST is accepted, go to RUN.
- **DRAIN_SUM**: the mirror of DRAIN_DIFF, with sum and diff swapped.
- **Output release.** A slot clears valid on TVALID & TREADY unless it reloads in the same cycle.
  - The two outputs drain independently: a can be consumed while b stalls.
  - No new join occurs until both slots are free or being freed.
- **err_count** saturates at all-ones.

## Timing
- **Reset** (asynchronous assert, synchronous-to-clock release):
  - a_TVALID = b_TVALID = 0, TLASTs 0, TDATA 0.
  - err_count = 0, state = RUN.
  - sum_TREADY = diff_TREADY = 0 while ap_rst_n is low.
- **Latency**: an accepted input beat appears on a/b the next cycle. Throughput is 1 beat/cycle when both consumers hold ready high.
- **Handshake**:
  - TREADY depends on TVALID (permitted direction only); TVALID never depends on TREADY.
  - Output data and last are stable while valid & ~ready.
- **Simultaneous events**:
  - Output consume and reload in the same cycle keeps valid high with the new data.
  - Mismatch on the same beat as a consumer stall: the beat is held at the input until can_load, and the state is evaluated only on acceptance.
- **Reset mid-packet**: slots are dropped, the state returns to RUN, and partial packets are not completed.

## Structure
- Package addsub_oot_pkg holds:
  - state encodings RUN=2'd0, DRAIN_SUM=2'd1, DRAIN_DIFF=2'd2;
  - the default WIDTH.
- Sub-module addsub_inv_lane: one component butterfly (s, d → (s+d)>>>1, (s−d)>>>1), instantiated for I and Q. It is purely combinational; all registers live in the top module.

## Test plan
- **Basic values**: sum 0x0006FFFE, diff 0x00020004 → a 0x00040001, b 0x0002FFFD one cycle later, both TLAST 0.
- **Extremes**:
  - sum 0x7FFF7FFF, diff 0x7FFF7FFF → a 0x7FFF7FFF, b 0x00000000.
  - sum 0x80008000, diff 0x7FFF7FFF → a 0xFFFFFFFF, b 0x80008000.
  - Odd case: sum 0xFFFB0005, diff 0 → a = b = 0xFFFD0002.
- **Independent backpressure**:
  - Stream 8-word packets with a_TREADY toggling every cycle and b_TREADY held high.
  - Required: no loss or duplication, TLAST on word 8 of both outputs, and no join while either slot is occupied and stalled.
- **Mismatch, sum early**:
  - sum packet of 4 words, diff packet of 6.
  - Required: 4 outputs with last on the 4th; err_count = 1; diff words 5–6 discarded; the next 4/4 packet pair aligns correctly.
- **Mismatch, diff early**: the mirror case (sum 6, diff 3) → 3 outputs, DRAIN_SUM discards 3 sum words, err_count = 2.
- **Reset mid-packet**:
  - Assert ap_rst_n low for 1 cycle on word 3 of 8.
  - Required: TVALIDs drop immediately (asynchronously), err_count = 0, and a fresh packet pair processes correctly afterwards.
